// File: rtl/mac_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : mac_tcdm_responder
// Brief    : Memory-side TCDM responder. Round-robin arbitration of MP request
//            ports onto one single-port 32-bit word memory, with a registered
//            one-cycle response routed back to the granted port.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tcdm_responder #(
    parameter int          MP        = 4,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic [MP-1:0]         tcdm_req,
    output logic [MP-1:0]         tcdm_gnt,
    input  logic [MP-1:0][31:0]   tcdm_add,
    input  logic [MP-1:0]         tcdm_wen,
    input  logic [MP-1:0][3:0]    tcdm_be,
    input  logic [MP-1:0][31:0]   tcdm_data,
    output logic [MP-1:0][31:0]   tcdm_r_data,
    output logic [MP-1:0]         tcdm_r_valid,
    output logic                  oor_o
);

    localparam int          PW       = (MP > 1) ? $clog2(MP) : 1;
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

    // Arbiter state and selected request
    logic [PW-1:0] r_ptr;
    logic          w_found_hi;
    logic          w_found_lo;
    logic [PW-1:0] w_sel_hi;
    logic [PW-1:0] w_sel_lo;
    logic          w_any;
    logic [PW-1:0] w_sel;
    logic          w_grant;

    logic [31:0]   w_add;
    logic          w_wen;
    logic [3:0]    w_be;
    logic [31:0]   w_data;
    logic [29:0]   w_word;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rsp_data;

    // Response stage
    logic          r_valid;
    logic [PW-1:0] r_port;
    logic          r_oor;

    // Word storage; intentionally not reset
    logic [31:0]   mem [DEPTH];

    // Round-robin search: first requester at or above ptr, else lowest requester
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        for (int k = 0; k < MP; k++) begin
            if (tcdm_req[k] && (k >= int'(r_ptr)) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_sel_hi   = PW'(k);
            end
            if (tcdm_req[k] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_sel_lo   = PW'(k);
            end
        end
        w_any = w_found_hi | w_found_lo;
        w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    // No grant under backpressure or while reset is held
    assign w_grant = w_any & ~stall_i & rst_ni;

    // One-hot grant to the selected port
    always_comb begin
        tcdm_gnt = '0;
        if (w_grant) begin
            tcdm_gnt[w_sel] = 1'b1;
        end
    end

    // Mux the winning port's request fields
    assign w_add  = tcdm_add[w_sel];
    assign w_wen  = tcdm_wen[w_sel];
    assign w_be   = tcdm_be[w_sel];
    assign w_data = tcdm_data[w_sel];

    // Word index relative to BASE_ADDR; no wrap, anything past the end is out of range
    assign w_word     = 30'((w_add - BASE_ADDR) >> 2);
    assign w_in_range = (w_add >= BASE_ADDR) && ({2'b00, w_word} < 32'(DEPTH));
    assign w_idx      = w_word[AW-1:0];

    // Response payload: read data, sentinel for out-of-range reads, zero for writes
    assign w_rsp_data = w_wen ? (w_in_range ? mem[w_idx] : OOR_DATA) : 32'h0;

    // Byte-lane masked write of in-range granted writes
    always_ff @(posedge clk_i) begin
        if (w_grant && !w_wen && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Round-robin pointer moves just past the granted port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_sel == PW'(MP - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    // Registered response; only the granted port's data register is updated
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_port      <= '0;
            r_oor       <= 1'b0;
            tcdm_r_data <= '0;
        end else begin
            r_valid <= w_grant;
            r_oor   <= w_grant & ~w_in_range;
            if (w_grant) begin
                r_port              <= w_sel;
                tcdm_r_data[w_sel]  <= w_rsp_data;
            end
        end
    end

    // Decode the response port into per-port valid strobes
    generate
        for (genvar p = 0; p < MP; p++) begin : g_rvalid
            assign tcdm_r_valid[p] = r_valid && (r_port == PW'(p));
        end
    endgenerate

    assign oor_o = r_oor;

endmodule
`default_nettype wire

// File: tb/tb_mac_tcdm_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mac_tcdm_responder
// Brief    : Self-checking bench for mac_tcdm_responder: directed scenarios
//            plus randomized multi-port traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tcdm_responder;

    localparam int          MP    = 4;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall;
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;
    logic                oor;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0]         mdl_mem [int];
    int                  mdl_ptr;
    logic [MP-1:0][31:0] mdl_rd;

    // Per-cycle observations and expectations
    int                  exp_gk;
    logic [MP-1:0]       exp_rv;
    logic                exp_oor;
    logic [MP-1:0]       obs_gnt;
    logic [MP-1:0]       obs_rv;
    logic [MP-1:0][31:0] obs_rd;
    logic                obs_oor;

    mac_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stall_i      (stall),
        .tcdm_req     (req),
        .tcdm_gnt     (gnt),
        .tcdm_add     (add),
        .tcdm_wen     (wen),
        .tcdm_be      (be),
        .tcdm_data    (data),
        .tcdm_r_data  (r_data),
        .tcdm_r_valid (r_valid),
        .oor_o        (oor)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [MP-1:0] onehot(input int k);
        logic [MP-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requester searching upward from ptr modulo MP
    function automatic int pick(input logic [MP-1:0] r, input int p, input logic st);
        if (st) return -1;
        for (int i = 0; i < MP; i++) begin
            if (r[(p + i) % MP]) return (p + i) % MP;
        end
        return -1;
    endfunction

    // Apply one granted access to the model and record its expected response
    task automatic model_access(input int k, output logic o);
        longint off;
        bit     inr;
        int     idx;
        logic [31:0] d;
        logic [31:0] old;
        off = longint'(add[k]) - longint'(BASE);
        inr = (off >= 0) && ((off / 4) < DEPTH);
        idx = int'(off / 4);
        d   = 32'h0;
        if (wen[k]) begin
            d = inr ? mdl_mem[idx] : 32'hDEAD_BEEF;
        end else if (inr) begin
            old = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[k][b]) old[8*b +: 8] = data[k][8*b +: 8];
            mdl_mem[idx] = old;
        end
        mdl_rd[k] = d;
        o         = !inr;
        mdl_ptr   = (k + 1) % MP;
    endtask

    // One bus cycle; entered just after a negedge with inputs already driven
    task automatic tick();
        #1;
        obs_gnt = gnt;
        exp_gk  = pick(req, mdl_ptr, stall);
        exp_rv  = '0;
        exp_oor = 1'b0;
        if (exp_gk >= 0) begin
            model_access(exp_gk, exp_oor);
            exp_rv = onehot(exp_gk);
        end
        @(posedge clk);
        #1;
        obs_rv  = r_valid;
        obs_rd  = r_data;
        obs_oor = oor;
        if (exp_gk >= 0) req[exp_gk] = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        add[p]  = a;
        wen[p]  = w;
        be[p]   = b;
        data[p] = d;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        stall   = 1'b0;
        mdl_ptr = 0;
        mdl_rd  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; req = '1; wen = '1; be = '1; add = '0; data = '0;
        mdl_ptr = 0; mdl_rd = '0;
        @(negedge clk); @(negedge clk);
        #1;
        n_run++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        n_run++; if (r_valid !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", r_valid); end
        n_run++; if (r_data !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", r_data); end
        n_run++; if (oor !== 1'b0) begin n_fail++; $display("FAIL reset_oor: got %b want 0", oor); end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        set_port(0, 32'h10, 1'b0, 4'hF, 32'hCAFE_F00D);
        tick();
        n_run++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt: got %b want 0001", obs_gnt); end
        n_run++; if (obs_rv !== 4'b0001) begin n_fail++; $display("FAIL wr_rvalid: got %b want 0001", obs_rv); end
        n_run++; if (obs_rd[0] !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", obs_rd[0]); end
        set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL rd_gnt: got %b want 0001", obs_gnt); end
        n_run++; if (obs_rv !== 4'b0001) begin n_fail++; $display("FAIL rd_rvalid: got %b want 0001", obs_rv); end
        n_run++; if (obs_rd[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_rdata: got %h want cafef00d", obs_rd[0]); end
        tick();
        n_run++; if (obs_rv !== 4'b0000) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b want 0000", obs_rv); end
    endtask

    task automatic test_partial_be();
        set_port(0, 32'h20, 1'b0, 4'hF, 32'h1122_3344);
        tick();
        set_port(0, 32'h20, 1'b0, 4'b0101, 32'hAABB_CCDD);
        tick();
        set_port(1, 32'h20, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_rv !== 4'b0010) begin n_fail++; $display("FAIL be_rvalid: got %b want 0010", obs_rv); end
        n_run++; if (obs_rd[1] !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_rdata: got %h want 11bb33dd", obs_rd[1]); end
    endtask

    task automatic test_contention();
        for (int p = 0; p < MP; p++) begin
            set_port(0, 32'h40 + 32'(4*p), 1'b0, 4'hF, 32'hA000_0000 + 32'(p * 32'h111));
            tick();
        end
        for (int rep = 0; rep < 2; rep++) begin
            // move the pointer away from 0 so the reset has something to undo
            set_port(1, 32'h40, 1'b1, 4'h0, 32'h0);
            tick();
            do_reset();
            for (int p = 0; p < MP; p++) set_port(p, 32'h40 + 32'(4*p), 1'b1, 4'h0, 32'h0);
            for (int c = 0; c < MP; c++) begin
                tick();
                n_run++; if (obs_gnt !== onehot(c)) begin n_fail++; $display("FAIL cont%0d_gnt%0d: got %b want %b", rep, c, obs_gnt, onehot(c)); end
                n_run++; if (obs_rv !== onehot(c)) begin n_fail++; $display("FAIL cont%0d_rvalid%0d: got %b want %b", rep, c, obs_rv, onehot(c)); end
                n_run++; if (obs_rd[c] !== 32'hA000_0000 + 32'(c * 32'h111)) begin n_fail++; $display("FAIL cont%0d_rdata%0d: got %h want %h", rep, c, obs_rd[c], 32'hA000_0000 + 32'(c * 32'h111)); end
            end
        end
    endtask

    task automatic test_stall();
        set_port(0, 32'h40, 1'b1, 4'h0, 32'h0);
        set_port(2, 32'h44, 1'b1, 4'h0, 32'h0);
        tick();
        stall = 1'b1;
        #1;
        n_run++; if (r_valid !== 4'b0001) begin n_fail++; $display("FAIL stall_keeps_rsp: got %b want 0001", r_valid); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_run++; if (obs_gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt%0d: got %b want 0000", c, obs_gnt); end
        end
        stall = 1'b0;
        tick();
        n_run++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL stall_release_gnt: got %b want 0100", obs_gnt); end
        n_run++; if (obs_rd[2] !== 32'hA000_0111) begin n_fail++; $display("FAIL stall_rdata: got %h want a0000111", obs_rd[2]); end
    endtask

    task automatic test_out_of_range();
        set_port(0, 32'h0, 1'b0, 4'hF, 32'h5A5A_1234);
        tick();
        set_port(0, 32'hFFC, 1'b0, 4'hF, 32'h0BAD_0BAD);
        tick();
        set_port(3, BASE + 32'h1000, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_rv !== 4'b1000) begin n_fail++; $display("FAIL oor_rvalid: got %b want 1000", obs_rv); end
        n_run++; if (obs_rd[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_rdata: got %h want deadbeef", obs_rd[3]); end
        n_run++; if (obs_oor !== 1'b1) begin n_fail++; $display("FAIL oor_pulse: got %b want 1", obs_oor); end
        tick();
        n_run++; if (obs_oor !== 1'b0) begin n_fail++; $display("FAIL oor_one_cycle: got %b want 0", obs_oor); end
        set_port(0, 32'h1000, 1'b0, 4'hF, 32'hFFFF_FFFF);
        tick();
        n_run++; if (obs_oor !== 1'b1) begin n_fail++; $display("FAIL oor_wr_pulse: got %b want 1", obs_oor); end
        set_port(0, 32'h0, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_rd[0] !== 32'h5A5A_1234) begin n_fail++; $display("FAIL oor_wr_alias: got %h want 5a5a1234", obs_rd[0]); end
        set_port(0, 32'hFFC, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_rd[0] !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL top_word: got %h want 0bad0bad", obs_rd[0]); end
        n_run++; if (obs_oor !== 1'b0) begin n_fail++; $display("FAIL top_word_oor: got %b want 0", obs_oor); end
    endtask

    task automatic test_reset_mid();
        set_port(2, 32'h48, 1'b1, 4'h0, 32'h0);
        #1;
        n_run++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_run++; if (r_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid: got %b want 0000", r_valid); end
        n_run++; if (r_data !== '0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", r_data); end
        n_run++; if (oor !== 1'b0) begin n_fail++; $display("FAIL mid_oor: got %b want 0", oor); end
        n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt_in_reset: got %b want 0000", gnt); end
        req = '0; mdl_ptr = 0; mdl_rd = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        set_port(1, 32'h40, 1'b1, 4'h0, 32'h0);
        set_port(3, 32'h4C, 1'b1, 4'h0, 32'h0);
        tick();
        n_run++; if (obs_gnt !== 4'b0010) begin n_fail++; $display("FAIL post_reset_gnt: got %b want 0010", obs_gnt); end
        tick();
        n_run++; if (obs_gnt !== 4'b1000) begin n_fail++; $display("FAIL post_reset_gnt2: got %b want 1000", obs_gnt); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i == 7) ? 32'hFFC : 32'h100 + 32'(4*i);
            set_port(0, pool[i], 1'b0, 4'hF, $urandom);
            tick();
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < MP; p++) begin
                if (!req[p] && ($urandom_range(0, 1) == 1)) begin
                    if ($urandom_range(0, 9) == 0)
                        set_port(p, 32'h1000 + ($urandom_range(0, 1) == 1 ? 32'hFFFF_0000 : 32'h0) + 32'($urandom_range(0, 255)),
                                 1'(($urandom)), 4'($urandom), $urandom);
                    else
                        set_port(p, pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3)),
                                 1'(($urandom)), 4'($urandom), $urandom);
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            tick();
            n_run++; if (obs_gnt !== onehot(exp_gk)) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, obs_gnt, onehot(exp_gk)); end
            n_run++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, obs_rv, exp_rv); end
            n_run++; if (obs_rd !== mdl_rd) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, obs_rd, mdl_rd); end
            n_run++; if (obs_oor !== exp_oor) begin n_fail++; $display("FAIL rnd_oor@%0d: got %b want %b", cyc, obs_oor, exp_oor); end
        end
        stall = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_write_read();
        test_partial_be();
        test_contention();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
